// File: rtl/debug_display_mux_if.sv
// Signal bundle between the debug display mux (slave) and the logic that
// feeds probes and buttons into it and consumes the display lines (master).
interface debug_display_mux_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 16,
    parameter int PC_W   = 8
);
    localparam int N_DIG = PC_W / 4 + DATA_W / 4;
    localparam int CS_W  = $clog2(NUM_CH);

    logic [PC_W-1:0]          pc_in;
    logic [NUM_CH*DATA_W-1:0] ch_data;
    logic                     ch_step;
    logic                     freeze;
    logic [6:0]               seg;
    logic [N_DIG-1:0]         digit_en;
    logic [CS_W-1:0]          ch_sel;
    logic [DATA_W-1:0]        show_value;
    logic [PC_W-1:0]          show_pc;
    logic                     frozen;

    modport master (
        output pc_in, ch_data, ch_step, freeze,
        input  seg, digit_en, ch_sel, show_value, show_pc, frozen
    );

    modport slave (
        input  pc_in, ch_data, ch_step, freeze,
        output seg, digit_en, ch_sel, show_value, show_pc, frozen
    );
endinterface

// File: rtl/debug_display_mux.sv
// Multiplexed 7-segment debug display: shows an aligned PC and a selectable
// probe channel, with debounced channel-step and freeze (snapshot) controls.
module debug_display_mux #(
    parameter int NUM_CH       = 4,
    parameter int DATA_W       = 16,
    parameter int PC_W         = 8,
    parameter int ALIGN_DEPTH  = 4,
    parameter int DEBOUNCE_CYC = 16,
    parameter int SCAN_DIV     = 1024
) (
    input logic                clock,
    input logic                reset,
    debug_display_mux_if.slave bus
);
    localparam int N_DIG = PC_W / 4 + DATA_W / 4;
    localparam int CS_W  = $clog2(NUM_CH);
    localparam int DB_W  = $clog2(DEBOUNCE_CYC + 1);
    localparam int PS_W  = $clog2(SCAN_DIV);
    localparam int DI_W  = $clog2(N_DIG);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(SCAN_DIV - 1);
    localparam logic [DI_W-1:0] DI_LAST = DI_W'(N_DIG - 1);
    localparam logic [CS_W-1:0] CS_LAST = CS_W'(NUM_CH - 1);

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] lit;
        case (nib)
            4'h0:    lit = 7'h3F;
            4'h1:    lit = 7'h06;
            4'h2:    lit = 7'h5B;
            4'h3:    lit = 7'h4F;
            4'h4:    lit = 7'h66;
            4'h5:    lit = 7'h6D;
            4'h6:    lit = 7'h7D;
            4'h7:    lit = 7'h07;
            4'h8:    lit = 7'h7F;
            4'h9:    lit = 7'h6F;
            4'hA:    lit = 7'h77;
            4'hB:    lit = 7'h7C;
            4'hC:    lit = 7'h39;
            4'hD:    lit = 7'h5E;
            4'hE:    lit = 7'h79;
            4'hF:    lit = 7'h71;
            default: lit = 7'h00;
        endcase
        return ~lit;
    endfunction

    logic [PC_W-1:0]   pc_pipe_q [ALIGN_DEPTH];
    logic [PC_W-1:0]   pc_pipe_d [ALIGN_DEPTH];
    logic [DATA_W-1:0] ch0_pipe_q [ALIGN_DEPTH];
    logic [DATA_W-1:0] ch0_pipe_d [ALIGN_DEPTH];
    logic [DATA_W-1:0] chx_q [NUM_CH-1];
    logic [DATA_W-1:0] chx_d [NUM_CH-1];
    logic [DATA_W-1:0] ch_al_s [NUM_CH];
    logic [PC_W-1:0]   pc_al_s;

    // Index 0 is ch_step, index 1 is freeze; acc_q[1] is the frozen state.
    logic [1:0]        sync1_q, sync1_d, sync2_q, sync2_d, acc_q, acc_d;
    logic [DB_W-1:0]   cnt_q [2];
    logic [DB_W-1:0]   cnt_d [2];
    logic              step_rise_s, frz_rise_s;

    logic [CS_W-1:0]   ch_sel_q, ch_sel_d;
    logic [PC_W-1:0]   snap_pc_q, snap_pc_d, show_pc_q, show_pc_d;
    logic [DATA_W-1:0] snap_val_q, snap_val_d, show_value_q, show_value_d;
    logic [PS_W-1:0]   psc_q, psc_d;
    logic [DI_W-1:0]   dig_idx_q, dig_idx_d;
    logic [N_DIG*4-1:0] disp_s;
    logic [3:0]        nib_s;
    logic [6:0]        seg_q, seg_d;
    logic [N_DIG-1:0]  digit_en_q, digit_en_d;

    assign pc_al_s = pc_pipe_q[ALIGN_DEPTH-1];
    assign disp_s  = {show_value_q, show_pc_q};
    assign nib_s   = disp_s[{dig_idx_q, 2'b00} +: 4];

    // Aligned view of every channel: channel 0 matches the PC latency.
    always_comb begin
        ch_al_s[0] = ch0_pipe_q[ALIGN_DEPTH-1];
        for (int k = 1; k < NUM_CH; k++) begin
            ch_al_s[k] = chx_q[k-1];
        end
    end

    // Next-state logic for alignment, debounce, selection, snapshot and scan.
    always_comb begin
        pc_pipe_d[0]  = bus.pc_in;
        ch0_pipe_d[0] = bus.ch_data[DATA_W-1:0];
        for (int i = 1; i < ALIGN_DEPTH; i++) begin
            pc_pipe_d[i]  = pc_pipe_q[i-1];
            ch0_pipe_d[i] = ch0_pipe_q[i-1];
        end
        for (int k = 1; k < NUM_CH; k++) begin
            chx_d[k-1] = bus.ch_data[k*DATA_W +: DATA_W];
        end

        sync1_d = {bus.freeze, bus.ch_step};
        sync2_d = sync1_q;
        for (int b = 0; b < 2; b++) begin
            acc_d[b] = acc_q[b];
            cnt_d[b] = {DB_W{1'b0}};
            if (sync2_q[b] != acc_q[b]) begin
                if (cnt_q[b] == DB_LAST) begin
                    acc_d[b] = sync2_q[b];
                end else begin
                    cnt_d[b] = cnt_q[b] + DB_W'(1);
                end
            end else begin
                cnt_d[b] = {DB_W{1'b0}};
            end
        end
        step_rise_s = acc_d[0] & ~acc_q[0];
        frz_rise_s  = acc_d[1] & ~acc_q[1];

        // A freeze accepted in the same cycle as a step suppresses the step.
        ch_sel_d = ch_sel_q;
        if (step_rise_s && !frz_rise_s && !acc_q[1]) begin
            if (ch_sel_q == CS_LAST) begin
                ch_sel_d = {CS_W{1'b0}};
            end else begin
                ch_sel_d = ch_sel_q + CS_W'(1);
            end
        end else begin
            ch_sel_d = ch_sel_q;
        end

        snap_pc_d  = snap_pc_q;
        snap_val_d = snap_val_q;
        if (frz_rise_s) begin
            snap_pc_d  = pc_al_s;
            snap_val_d = ch_al_s[ch_sel_q];
        end else begin
            snap_pc_d  = snap_pc_q;
            snap_val_d = snap_val_q;
        end

        if (acc_q[1]) begin
            show_pc_d    = snap_pc_q;
            show_value_d = snap_val_q;
        end else begin
            show_pc_d    = pc_al_s;
            show_value_d = ch_al_s[ch_sel_q];
        end

        psc_d     = psc_q + PS_W'(1);
        dig_idx_d = dig_idx_q;
        if (psc_q == PS_LAST) begin
            psc_d = {PS_W{1'b0}};
            if (dig_idx_q == DI_LAST) begin
                dig_idx_d = {DI_W{1'b0}};
            end else begin
                dig_idx_d = dig_idx_q + DI_W'(1);
            end
        end else begin
            dig_idx_d = dig_idx_q;
        end

        seg_d      = seg_decode(nib_s);
        digit_en_d = ~({{(N_DIG-1){1'b0}}, 1'b1} << dig_idx_q);
    end

    // State registers; reset clears all state and blanks the display.
    always_ff @(posedge clock) begin
        if (!reset) begin
            pc_pipe_q    <= '{default: {PC_W{1'b0}}};
            ch0_pipe_q   <= '{default: {DATA_W{1'b0}}};
            chx_q        <= '{default: {DATA_W{1'b0}}};
            sync1_q      <= 2'b00;
            sync2_q      <= 2'b00;
            acc_q        <= 2'b00;
            cnt_q        <= '{default: {DB_W{1'b0}}};
            ch_sel_q     <= {CS_W{1'b0}};
            snap_pc_q    <= {PC_W{1'b0}};
            snap_val_q   <= {DATA_W{1'b0}};
            show_pc_q    <= {PC_W{1'b0}};
            show_value_q <= {DATA_W{1'b0}};
            psc_q        <= {PS_W{1'b0}};
            dig_idx_q    <= {DI_W{1'b0}};
            seg_q        <= 7'h7F;
            digit_en_q   <= {N_DIG{1'b1}};
        end else begin
            pc_pipe_q    <= pc_pipe_d;
            ch0_pipe_q   <= ch0_pipe_d;
            chx_q        <= chx_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            ch_sel_q     <= ch_sel_d;
            snap_pc_q    <= snap_pc_d;
            snap_val_q   <= snap_val_d;
            show_pc_q    <= show_pc_d;
            show_value_q <= show_value_d;
            psc_q        <= psc_d;
            dig_idx_q    <= dig_idx_d;
            seg_q        <= seg_d;
            digit_en_q   <= digit_en_d;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.digit_en   = digit_en_q;
    assign bus.ch_sel     = ch_sel_q;
    assign bus.show_value = show_value_q;
    assign bus.show_pc    = show_pc_q;
    assign bus.frozen     = acc_q[1];
endmodule

// File: tb/tb_debug_display_mux.sv
// Scoreboard bench for debug_display_mux: stimulus queues expectations,
// a negedge monitor pops and compares them as the display outputs evolve.
module tb_debug_display_mux;
    localparam int NUM_CH       = 4;
    localparam int DATA_W       = 16;
    localparam int PC_W         = 8;
    localparam int ALIGN_DEPTH  = 4;
    localparam int DEBOUNCE_CYC = 16;
    localparam int SCAN_DIV     = 4;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    debug_display_mux_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .PC_W(PC_W)) bus ();

    debug_display_mux #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .PC_W(PC_W), .ALIGN_DEPTH(ALIGN_DEPTH),
        .DEBOUNCE_CYC(DEBOUNCE_CYC), .SCAN_DIV(SCAN_DIV)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    typedef enum int {F_PC, F_VAL, F_FRZ, F_SEL, F_SEG, F_DEN} fld_e;
    typedef struct {
        int          due;
        fld_e        fld;
        logic [31:0] exp;
        string       name;
    } chk_t;
    typedef struct {
        logic [5:0] den;
        logic [6:0] seg;
    } scan_t;

    chk_t       tq[$];
    logic [1:0] sel_q[$];
    scan_t      scan_q[$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    bit         scan_on = 1'b0;
    bit         scan_sync = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic expect_at(input int dly, input fld_e f, input logic [31:0] v, input string n);
        chk_t c;
        c.due = cyc + dly;
        c.fld = f;
        c.exp = v;
        c.name = n;
        tq.push_back(c);
    endtask

    function automatic logic [31:0] obs(input fld_e f);
        case (f)
            F_PC:    return 32'(bus.show_pc);
            F_VAL:   return 32'(bus.show_value);
            F_FRZ:   return 32'(bus.frozen);
            F_SEL:   return 32'(bus.ch_sel);
            F_SEG:   return 32'(bus.seg);
            F_DEN:   return 32'(bus.digit_en);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic push_scan(input logic [5:0] d, input logic [6:0] s);
        scan_t e;
        e.den = d;
        e.seg = s;
        scan_q.push_back(e);
    endtask

    // Bounce for 3 cycles, then a clean 20-cycle press and a long release.
    task automatic press_step();
        bus.ch_step = 1'b1; tick(3);
        bus.ch_step = 1'b0; tick(3);
        bus.ch_step = 1'b1; tick(20);
        bus.ch_step = 1'b0; tick(25);
    endtask

    // Monitor: timed checks, ch_sel change checks and digit-scan checks.
    initial begin : monitor
        logic [1:0] prev_sel;
        logic [5:0] prev_den;
        logic [1:0] want_sel;
        scan_t      s;
        int         hold;
        prev_sel = 2'd0;
        prev_den = 6'h3F;
        hold = 0;
        forever begin
            @(negedge clock);
            for (int i = 0; i < tq.size(); ) begin
                if (tq[i].due <= cyc) begin
                    total++;
                    if (obs(tq[i].fld) !== tq[i].exp) begin
                        bad++;
                        $display("FAIL %s: got %0h want %0h (cycle %0d)", tq[i].name, obs(tq[i].fld), tq[i].exp, cyc);
                    end
                    tq.delete(i);
                end else begin
                    i++;
                end
            end
            if (bus.ch_sel !== prev_sel) begin
                total++;
                if (sel_q.size() == 0) begin
                    bad++;
                    $display("FAIL ch_sel_unexpected: got %0d want %0d (cycle %0d)", bus.ch_sel, prev_sel, cyc);
                end else begin
                    want_sel = sel_q.pop_front();
                    if (bus.ch_sel !== want_sel) begin
                        bad++;
                        $display("FAIL ch_sel_step: got %0d want %0d", bus.ch_sel, want_sel);
                    end
                end
                prev_sel = bus.ch_sel;
            end
            if (bus.digit_en !== prev_den) begin
                if (scan_on && !scan_sync && bus.digit_en === 6'h3E) begin
                    scan_sync = 1'b1;
                end else if (scan_sync && scan_q.size() > 0) begin
                    total++;
                    if (hold != SCAN_DIV) begin
                        bad++;
                        $display("FAIL scan_hold: got %0d want %0d", hold, SCAN_DIV);
                    end
                end
                if (scan_sync && scan_q.size() > 0) begin
                    s = scan_q.pop_front();
                    total++;
                    if (bus.digit_en !== s.den || bus.seg !== s.seg) begin
                        bad++;
                        $display("FAIL scan_digit: got en=%b seg=%b want en=%b seg=%b", bus.digit_en, bus.seg, s.den, s.seg);
                    end
                    if (scan_q.size() == 0) begin
                        scan_sync = 1'b0;
                        scan_on = 1'b0;
                    end
                end
                hold = 0;
            end
            hold++;
            prev_den = bus.digit_en;
        end
    end

    initial begin : stimulus
        reset = 1'b0;
        bus.pc_in = 8'h00;
        bus.ch_data = 64'h0;
        bus.ch_step = 1'b0;
        bus.freeze = 1'b0;
        tick(3);
        expect_at(0, F_SEG, 32'h7F, "rst_seg");
        expect_at(0, F_DEN, 32'h3F, "rst_digit_en");
        expect_at(0, F_FRZ, 32'h0, "rst_frozen");
        expect_at(0, F_SEL, 32'h0, "rst_ch_sel");
        expect_at(0, F_PC, 32'h0, "rst_show_pc");
        expect_at(0, F_VAL, 32'h0, "rst_show_value");

        // PC and channel 0 latency: ALIGN_DEPTH stages plus the display register.
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.pc_in = 8'(i);
            bus.ch_data[15:0] = 16'h1000 + 16'(i);
            expect_at(ALIGN_DEPTH + 1, F_PC, 32'(i), "pc_align");
            expect_at(ALIGN_DEPTH + 1, F_VAL, 32'h1000 + 32'(i), "ch0_align");
            tick(1);
        end
        tick(6);

        // Four steps wrap 0->1->2->3->0, a fifth lands on channel 1.
        for (int n = 1; n <= 5; n++) begin
            sel_q.push_back(2'(n % NUM_CH));
            press_step();
        end
        bus.ch_step = 1'b1; tick(3);
        bus.ch_step = 1'b0; tick(25);
        expect_at(0, F_SEL, 32'h1, "bounce_only");

        // Freeze with a coincident step: freeze wins, snapshot holds 0xBEEF.
        bus.ch_data[31:16] = 16'hBEEF;
        tick(3);
        bus.freeze = 1'b1;
        bus.ch_step = 1'b1;
        expect_at(DEBOUNCE_CYC + 1, F_FRZ, 32'h0, "frz_not_yet");
        expect_at(DEBOUNCE_CYC + 2, F_FRZ, 32'h1, "frz_accept");
        expect_at(DEBOUNCE_CYC + 3, F_VAL, 32'hBEEF, "frz_snap_val");
        tick(20);
        bus.ch_step = 1'b0;
        bus.ch_data[31:16] = 16'h1234;
        bus.pc_in = 8'h55;
        expect_at(5, F_VAL, 32'hBEEF, "frz_hold_val");
        expect_at(5, F_PC, 32'h09, "frz_hold_pc");
        tick(25);
        press_step();
        expect_at(0, F_VAL, 32'hBEEF, "frz_step_ignored");
        expect_at(0, F_SEL, 32'h1, "frz_sel_kept");
        tick(1);
        bus.freeze = 1'b0;
        expect_at(DEBOUNCE_CYC + 1, F_FRZ, 32'h1, "unfrz_not_yet");
        expect_at(DEBOUNCE_CYC + 2, F_FRZ, 32'h0, "unfrz_accept");
        expect_at(DEBOUNCE_CYC + 2, F_VAL, 32'hBEEF, "unfrz_last_snap");
        expect_at(DEBOUNCE_CYC + 3, F_VAL, 32'h1234, "unfrz_live_val");
        expect_at(DEBOUNCE_CYC + 3, F_PC, 32'h55, "unfrz_live_pc");
        tick(25);

        // Freeze 0x3A / 0xC0DE, scramble inputs, then walk the scan.
        bus.pc_in = 8'h3A;
        bus.ch_data[31:16] = 16'hC0DE;
        tick(8);
        bus.freeze = 1'b1;
        tick(22);
        bus.pc_in = 8'hC3;
        bus.ch_data[31:16] = 16'h0000;
        expect_at(0, F_FRZ, 32'h1, "scan_frozen");
        push_scan(6'b111110, 7'h08);
        push_scan(6'b111101, 7'h30);
        push_scan(6'b111011, 7'h06);
        push_scan(6'b110111, 7'h21);
        push_scan(6'b101111, 7'h40);
        push_scan(6'b011111, 7'h46);
        push_scan(6'b111110, 7'h08);
        scan_on = 1'b1;
        for (int i = 0; i < 80 && scan_q.size() > 0; i++) begin
            tick(1);
        end
        total++;
        if (scan_q.size() != 0) begin
            bad++;
            $display("FAIL scan_timeout: got %0d pending want 0", scan_q.size());
        end

        // Reset while frozen and scanning.
        sel_q.push_back(2'd0);
        reset = 1'b0;
        expect_at(1, F_SEG, 32'h7F, "midrst_seg");
        expect_at(1, F_DEN, 32'h3F, "midrst_digit_en");
        expect_at(1, F_FRZ, 32'h0, "midrst_frozen");
        expect_at(1, F_SEL, 32'h0, "midrst_ch_sel");
        tick(3);

        // Freeze still high after reset: re-freezes only after full debounce.
        reset = 1'b1;
        expect_at(DEBOUNCE_CYC + 1, F_FRZ, 32'h0, "refrz_not_yet");
        expect_at(DEBOUNCE_CYC + 2, F_FRZ, 32'h1, "refrz_accept");
        expect_at(DEBOUNCE_CYC + 3, F_PC, 32'hC3, "refrz_pc");
        expect_at(DEBOUNCE_CYC + 3, F_VAL, 32'h1009, "refrz_val");
        tick(25);

        total++;
        if (sel_q.size() != 0 || tq.size() != 0) begin
            bad++;
            $display("FAIL pending_checks: got %0d want 0", sel_q.size() + tq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/debug_display_mux.md
DEBUG_DISPLAY_MUX -- requirements
Module: debug_display_mux

Interface
REQ-001 Parameter NUM_CH, default 4, number of 16-bit probe channels selectable for display (legal 2..8).
REQ-002 Parameter DATA_W, default 16, probe channel width, multiple of 4.
REQ-003 Parameter PC_W, default 8, program counter width, multiple of 4.
REQ-004 Parameter ALIGN_DEPTH, default 4, pipeline alignment depth for PC and channel 0 (legal 1..8).
REQ-005 Parameter DEBOUNCE_CYC, default 16, consecutive stable cycles required to accept a button level.
REQ-006 Parameter SCAN_DIV, default 1024, clock cycles per displayed digit (legal >=2).
REQ-007 Derived N_DIG = PC_W/4 + DATA_W/4; CS_W = clog2(NUM_CH).
REQ-008 clock  input  1  single clock for all logic.
REQ-009 reset  input  1  reset, synchronous, active-low.
REQ-010 pc_in  input  PC_W  live program counter from the processor.
REQ-011 ch_data  input  NUM_CH*DATA_W  probe channels, channel k at bits [k*DATA_W +: DATA_W]; channel 0 is the instruction.
REQ-012 ch_step  input  1  raw, unsynchronised push button, high = pressed.
REQ-013 freeze  input  1  raw slide switch, high = hold display.
REQ-014 seg  output  7  shared segment lines, bit0=a ... bit6=g, active-low.
REQ-015 digit_en  output  N_DIG  one-hot active-low digit enable.
REQ-016 ch_sel  output  CS_W  currently selected channel.
REQ-017 show_value  output  DATA_W  value currently presented on data digits.
REQ-018 show_pc  output  PC_W  PC value currently presented on PC digits.
REQ-019 frozen  output  1  high while snapshot is displayed.

Function
REQ-020 pc_in and channel 0 SHALL each pass through an ALIGN_DEPTH-stage register chain; channels 1..NUM_CH-1 SHALL pass through exactly one register.
REQ-021 ch_step and freeze SHALL each be synchronised through two flops before any use.
REQ-022 Debouncer per input: counter resets on any synchronised-level change vs. accepted level; when counter reaches DEBOUNCE_CYC-1 with level unchanged, accepted level updates next cycle.
REQ-023 Rising edge of accepted ch_step SHALL increment ch_sel by 1, wrapping NUM_CH-1 -> 0; ignored while frozen=1.
REQ-024 Rising edge of accepted freeze SHALL, in the same cycle frozen goes 1, capture aligned PC and aligned value of ch_sel into snapshot registers.
REQ-025 Falling edge of accepted freeze SHALL clear frozen; live values resume the next cycle.
REQ-026 Live mode: show_value = aligned channel ch_sel, show_pc = aligned PC, both registered (1 cycle after alignment output).
REQ-027 Frozen mode: show_value/show_pc SHALL hold snapshot regardless of inputs.
REQ-028 Scan prescaler counts 0..SCAN_DIV-1 and wraps; on wrap, digit index advances 0..N_DIG-1 and wraps to 0.
REQ-029 Digit index i < PC_W/4 shows show_pc nibble i (LS first); index PC_W/4+j shows show_value nibble j.
REQ-030 seg and digit_en SHALL be registered together: both reflect the same digit index, updated in the cycle after the index changes; digit_en has exactly one 0 bit outside reset.
REQ-031 seg SHALL encode hex 0-9, A, b, C, d, E, F in standard glyphs, active-low (e.g. 0 -> 7'b1000000 with bit6=g).
REQ-032 ch_step edge coincident with freeze-accept edge: freeze wins, ch_sel unchanged.

Reset
REQ-033 While reset=0 at a clock edge: all alignment stages, snapshots, show_value, show_pc, ch_sel, frozen, prescaler, digit index and debounce counters SHALL be 0; accepted button levels 0.
REQ-034 During reset seg SHALL be 7'h7F and digit_en all ones (display blank); scanning starts at index 0 on the first cycle after reset=1.
REQ-035 Reset mid-freeze or mid-debounce SHALL discard state; a still-high freeze input re-freezes only after full debounce.

Verification
REQ-036 pc_in steps 0x00,0x01,0x02...; reset released -> show_pc equals pc_in from ALIGN_DEPTH+1 cycles earlier (5 with defaults).
REQ-037 ch_step pulsed 3 cycles (bounce) then held 20 cycles, 4 times -> ch_sel 0->1->2->3->0; bounce pulse alone causes no change.
REQ-038 ch_data ch1=0xBEEF, freeze asserted, then ch1 driven 0x1234 -> show_value stays 0xBEEF, frozen=1; release -> 0x1234 after debounce+1.
REQ-039 SCAN_DIV=4, show_pc=0x3A, show_value=0xC0DE -> digit_en walks 111110..011111, seg digits A,3,E,d,0,C, each held 4 cycles.
REQ-040 reset driven low mid-scan with frozen=1 -> next cycle seg=7'h7F, digit_en=6'h3F, frozen=0, ch_sel=0.
